mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all ports, SHALL be honoured.
REQ-002 Parameter DATA_W, 32, data width of all ports, SHALL be honoured.
REQ-003 Parameter TIMEOUT, 16, maximum cycles to wait for mem_r_valid, SHALL be honoured (legal range 2..255).
REQ-004 Ports SHALL be:
 CLK  in  1  single clock, rising edge
 RES  in  1  reset, asynchronous, active-low
 instr_req  in  1  fetch request
 instr_addr  in  ADDR_W  fetch address
 instr_gnt  out  1  fetch granted
 instr_r_valid  out  1  fetch data valid
 instr_rdata  out  DATA_W  fetch data
 data_req  in  1  load/store request
 data_we  in  1  1 = store, 0 = load
 data_addr  in  ADDR_W  load/store address
 data_wdata  in  DATA_W  store data
 data_gnt  out  1  load/store granted
 data_r_valid  out  1  load data valid
 data_rdata  out  DATA_W  load data
 mem_req  out  1  shared memory request
 mem_we  out  1  shared memory write enable
 mem_addr  out  ADDR_W  shared memory address
 mem_wdata  out  DATA_W  shared memory write data
 mem_gnt  in  1  memory accepted request
 mem_r_valid  in  1  memory read data valid
 mem_rdata  in  DATA_W  memory read data
 err_timeout  out  1  one-cycle pulse, read response lost

Function
REQ-005 FSM states SHALL be ARB, WAIT_RVALID; one transaction outstanding at most.
REQ-006 ARB: if either req high, mem_req SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL carry the selected requester's fields (instr: mem_we=0, mem_wdata=0).
REQ-007 Selection when only one req high SHALL pick that requester.
REQ-008 Selection when both high SHALL be round-robin: the requester not granted last; last_owner resets to data, so instr wins the first tie.
REQ-009 Once mem_req is driven for a requester and mem_gnt is low, selection SHALL be locked to it until granted, even if the other requester raises req.
REQ-010 A requester that drops req before grant SHALL release the lock the same cycle.
REQ-011 mem_gnt SHALL be forwarded combinationally to the selected requester's gnt only; the other gnt stays 0.
REQ-012 On grant of a load or fetch: owner and last_owner SHALL update, counter clears, next state WAIT_RVALID.
REQ-013 On grant of a store: last_owner SHALL update, state stays ARB; no response expected; new arbitration allowed next cycle.
REQ-014 WAIT_RVALID: mem_req SHALL be 0, both gnt 0; mem_r_valid and mem_rdata SHALL be forwarded combinationally to the owner's r_valid/rdata, then ARB next cycle.
REQ-015 Non-owner r_valid SHALL be 0 and rdata 0 at all times.
REQ-016 WAIT_RVALID: 8-bit counter SHALL increment each cycle without mem_r_valid; when it reaches TIMEOUT-1 the block SHALL assert owner r_valid with rdata = 0 and err_timeout = 1 for one cycle, then return to ARB.
REQ-017 mem_r_valid in the same cycle as timeout expiry SHALL win: real data forwarded, err_timeout 0.
REQ-018 mem_r_valid received in ARB (spurious/late) SHALL be ignored; no r_valid forwarded.
REQ-019 Zero-wait memory (mem_gnt same cycle as mem_req, mem_r_valid next cycle) SHALL sustain one read per two cycles.

Reset
REQ-020 RES low SHALL asynchronously force state ARB, owner = none, last_owner = data, counter 0.
REQ-021 During and after reset all outputs SHALL be 0 until a req is sampled in ARB.
REQ-022 Reset mid-transaction SHALL drop the outstanding response; a later mem_r_valid SHALL be ignored per REQ-018.

Verification
REQ-023 Both req rise together, addr instr=0x100, data=0x200 load, mem_gnt=1 -> instr_gnt=1, mem_addr=0x100; after instr r_valid, next grant data_gnt=1, mem_addr=0x200.
REQ-024 instr_req high, mem_gnt held 0 three cycles, data_req rises cycle 2 -> mem_addr stays instr_addr, data_gnt=0 until instr granted.
REQ-025 Store data_addr=0x40, wdata=0xCAFEF00D, mem_gnt=1 -> mem_we=1, data_gnt=1, state ARB next cycle, no data_r_valid.
REQ-026 Fetch granted, mem_r_valid never arrives, TIMEOUT=16 -> instr_r_valid=1, instr_rdata=0, err_timeout=1 exactly 16 cycles after grant.
REQ-027 RES low during WAIT_RVALID, then mem_r_valid=1 with rdata=0x1234 -> no r_valid on either port, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: two-requester (fetch / load-store) arbiter onto one memory  |
// | port, round-robin with grant lock and read-response timeout.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              instr_gnt,
  output logic              instr_r_valid,
  output logic [DATA_W-1:0] instr_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_r_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_r_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout
);

  localparam logic [0:0] c_ST_ARB      = 1'b0;
  localparam logic [0:0] c_ST_WAIT     = 1'b1;
  localparam logic [7:0] c_TMO_LAST    = 8'(TIMEOUT - 1);

  // Requester identity: 0 = instr, 1 = data.
  logic [0:0] r_state, w_state_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_last,  w_last_nxt;
  logic       r_lock,  w_lock_nxt;
  logic       r_lock_sel, w_lock_sel_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;

  logic w_any;
  logic w_lock_live;
  logic w_sel;
  logic w_store;
  logic w_tmo;
  logic w_arb_req;
  logic w_wait;

  assign w_any       = instr_req | data_req;
  // A held selection is only honoured while its requester keeps req asserted.
  assign w_lock_live = r_lock & (r_lock_sel ? data_req : instr_req);
  assign w_sel       = w_lock_live ? r_lock_sel :
                       (instr_req & data_req) ? ~r_last : data_req;
  assign w_store     = w_sel & data_we;
  assign w_tmo       = (r_cnt == c_TMO_LAST);
  // Outputs are held quiet while reset is asserted.
  assign w_arb_req   = RES & (r_state == c_ST_ARB) & w_any;
  assign w_wait      = RES & (r_state == c_ST_WAIT);

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_state    <= c_ST_ARB;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_lock     <= 1'b0;
      r_lock_sel <= 1'b0;
      r_cnt      <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_lock     <= w_lock_nxt;
      r_lock_sel <= w_lock_sel_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    w_lock_nxt     = 1'b0;
    w_lock_sel_nxt = r_lock_sel;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      c_ST_ARB: begin
        if (w_any) begin
          if (mem_gnt) begin
            w_last_nxt = w_sel;
            if (!w_store) begin
              w_state_nxt = c_ST_WAIT;
              w_owner_nxt = w_sel;
              w_cnt_nxt   = 8'd0;
            end
          end else begin
            w_lock_nxt     = 1'b1;
            w_lock_sel_nxt = w_sel;
          end
        end
      end
      default: begin
        if (mem_r_valid || w_tmo) begin
          w_state_nxt = c_ST_ARB;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    instr_gnt     = 1'b0;
    data_gnt      = 1'b0;
    instr_r_valid = 1'b0;
    instr_rdata   = '0;
    data_r_valid  = 1'b0;
    data_rdata    = '0;
    err_timeout   = 1'b0;
    if (w_arb_req) begin
      mem_req = 1'b1;
      if (w_sel) begin
        mem_we    = data_we;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        data_gnt  = mem_gnt;
      end else begin
        mem_addr  = instr_addr;
        instr_gnt = mem_gnt;
      end
    end
    if (w_wait) begin
      // Real data wins over a timeout expiring in the same cycle.
      err_timeout = ~mem_r_valid & w_tmo;
      if (r_owner) begin
        data_r_valid = mem_r_valid | w_tmo;
        data_rdata   = mem_r_valid ? mem_rdata : '0;
      end else begin
        instr_r_valid = mem_r_valid | w_tmo;
        instr_rdata   = mem_r_valid ? mem_rdata : '0;
      end
    end
  end

endmodule
`default_nettype wire
